uart_rx_oversampled: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 38 +++
 rtl/uart_rx_oversampled.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the receiver, transmitter and baud
//   generator.
//   - rx_state_e          : receiver FSM states (2-bit encoding)
//   - OVERSAMPLE_DEFAULT  : baud_tick pulses per bit period (power of 2, >= 4)
//   - DATA_BITS_DEFAULT   : data bits per frame (no parity, one stop bit)
//   - BAUD_DIVISOR        : sysclk cycles per baud_tick for the default
//                           clock / baud rate pair
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  localparam int SYSCLK_HZ    = 50_000_000;
  localparam int BAUD_RATE    = 115_200;
  // Integer divide: the baud generator emits one tick every BAUD_DIVISOR
  // sysclk cycles, giving OVERSAMPLE_DEFAULT ticks per bit.
  localparam int BAUD_DIVISOR = SYSCLK_HZ / (BAUD_RATE * OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for an asynchronous input. The reset value is a
//   parameter so idle-high lines (UART) and idle-low inputs (switches) both
//   come out of reset in their inactive state.
//   Ports:
//     sysclk   in   system clock
//     reset    in   synchronous, active-high reset
//     i_async  in   asynchronous input
//     o_sync   out  synchronized copy of i_async (second flop)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge sysclk) begin
    // NOTE: non-blocking assignments make both flops sample their pre-edge
    // inputs; blocking ones would collapse the chain into a single flop.
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
//   UART receiver front end. The line is synchronized, then sampled at
//   OVERSAMPLE x baud using baud_tick. The start bit is confirmed at its
//   midpoint, data bits are shifted in LSB first, and the stop bit decides
//   between a good-byte pulse and a frame-error pulse.
//   Ports:
//     sysclk        in   system clock, all logic on its rising edge
//     reset         in   synchronous, active-high reset
//     baud_tick     in   one-cycle enable at OVERSAMPLE x baud rate
//     uart_rx       in   asynchronous serial line, idles high
//     rx_status     out  one-cycle pulse: a good byte is on rx_data
//     rx_data       out  last correctly received byte (held indefinitely)
//     rx_frame_err  out  one-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 uart_rx,
  output logic                 rx_status,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_e            r_state;
  rx_state_e            w_state_next;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_status;
  logic                 r_frame_err;
  logic                 w_tick_mid;
  logic                 w_tick_last;
  logic                 w_good;
  logic                 w_bad;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .sysclk  (sysclk),
    .reset   (reset),
    .i_async (uart_rx),
    .o_sync  (w_rx_s)
  );

  assign w_tick_mid  = (r_tick_cnt == TICK_MID);
  assign w_tick_last = (r_tick_cnt == TICK_LAST);

  // State register
  always_ff @(posedge sysclk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; nothing moves without a tick.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch
    // is inferred.
    w_state_next = r_state;
    if (baud_tick) begin
      unique case (r_state)
        IDLE:    if (!w_rx_s) w_state_next = START;
        // Mid start bit: a high line here was a glitch, not a frame.
        START:   if (w_tick_mid) w_state_next = w_rx_s ? IDLE : DATA;
        DATA:    if (w_tick_last && (r_bit_cnt == BIT_LAST)) w_state_next = STOP;
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        STOP:    if (w_tick_last) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output decode: the stop-bit sample decides which pulse fires.
  always_comb begin
    w_good = 1'b0;
    w_bad  = 1'b0;
    if (baud_tick && (r_state == STOP) && w_tick_last) begin
      w_good = w_rx_s;
      w_bad  = !w_rx_s;
    end
  end

  // Counters and shift register
  always_ff @(posedge sysclk) begin
    // NOTE: the shift register is reset along with the counters so every
    // datapath flop has a defined value straight out of reset.
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else if (baud_tick) begin
      unique case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
        START: begin
          if (w_tick_mid) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
        DATA: begin
          if (w_tick_last) begin
            r_tick_cnt <= '0;
            // Right shift with the new bit at the MSB: after DATA_BITS
            // samples the first bit on the line sits in bit 0.
            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt != BIT_LAST) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
        STOP: begin
          if (w_tick_last) r_tick_cnt <= '0;
          else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
        default: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Registered outputs: pulses last exactly one cycle, data only moves on a
  // good frame.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_status <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_data   <= '0;
    end else begin
      r_rx_status <= w_good;
      r_frame_err <= w_bad;
      if (w_good) r_rx_data <= r_shift;
    end
  end

  assign rx_status    = r_rx_status;
  assign rx_frame_err = r_frame_err;
  assign rx_data      = r_rx_data;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
//   Frame-level reference: each transmitted frame pushes one expected event
//   (good byte or framing error, plus the tick count at its start edge).
//   A negedge compare process matches every DUT pulse against that queue,
//   checks pulse timing in bit periods, and checks rx_data every cycle.
//   16 ticks per bit, one tick every 4 sysclk.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

  localparam int OS        = 16;
  localparam int DB        = 8;
  // Start edge -> pulse: 9.5 bit periods to mid stop bit, plus the sync and
  // tick-phase delay of about one tick.
  localparam int LAT_LO    = 152;
  localparam int LAT_HI    = 154;
  localparam int LAT_LIMIT = 170;

  typedef struct {
    bit          good;
    logic [7:0]  data;
    int          edge_tick;
  } exp_t;

  logic          sysclk;
  logic          reset;
  logic          baud_tick;
  logic          uart_rx;
  logic          rx_status;
  logic [DB-1:0] rx_data;
  logic          rx_frame_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_total = 0;
  bit   tick_gate = 1'b0;
  bit   cmp_en = 1'b0;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;
  int   status_cnt = 0;
  int   err_cnt = 0;
  int   last_status_tick = 0;
  int   prev_status_tick = 0;
  logic prev_status = 1'b0;
  logic prev_err = 1'b0;

  uart_rx_oversampled #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .uart_rx      (uart_rx),
    .rx_status    (rx_status),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Tick generator: one tick every 4 cycles, frozen while tick_gate is set.
  initial begin
    int div_cnt;
    div_cnt   = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge sysclk);
      if (tick_gate) begin
        baud_tick = 1'b0;
      end else begin
        div_cnt   = (div_cnt + 1) % 4;
        baud_tick = (div_cnt == 0);
      end
    end
  end

  always @(posedge sysclk) if (baud_tick) tick_total <= tick_total + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val >= lo && val <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, val, lo, hi, $time);
  endtask

  // Compare process
  always @(negedge sysclk) begin
    if (cmp_en) begin
      if (rx_status || rx_frame_err)
        check("status_err_exclusive", {31'd0, rx_status & rx_frame_err}, 32'd0);
      if (rx_status) begin
        check("status_width", {31'd0, prev_status}, 32'd0);
        status_cnt++;
        prev_status_tick = last_status_tick;
        last_status_tick = tick_total;
        if (exp_q.size() == 0) begin
          check("unexpected_status", {31'd0, rx_status}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("status_kind", {31'd0, rx_status}, {31'd0, e.good});
          check("status_data", {24'd0, rx_data}, {24'd0, e.data});
          check_range("status_latency", tick_total - e.edge_tick, LAT_LO, LAT_HI);
          if (e.good) model_data = e.data;
        end
      end
      if (rx_frame_err) begin
        check("err_width", {31'd0, prev_err}, 32'd0);
        err_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_err", {31'd0, rx_frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err_kind", {31'd0, rx_frame_err}, {31'd0, !e.good});
          check_range("err_latency", tick_total - e.edge_tick, LAT_LO, LAT_HI);
        end
      end
      if (exp_q.size() > 0 && (tick_total - exp_q[0].edge_tick) > LAT_LIMIT) begin
        check_range("pulse_timeout", tick_total - exp_q[0].edge_tick, LAT_LO, LAT_HI);
        void'(exp_q.pop_front());
      end
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
      prev_status = rx_status;
      prev_err    = rx_frame_err;
    end
  end

  // Returns just after the posedge of the n-th tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge sysclk);
        guard++;
        if (guard > 500) begin
          $display("FAIL tick_wait: no baud_tick within %0d cycles", guard);
          $fatal(1, "tick generator stalled");
        end
      end while (!baud_tick);
    end
  endtask

  // One frame: start, DB data bits LSB first, stop bit stop_ok, then gap
  // idle ticks. abort_bit >= 0 pulses reset mid data bit and abandons the
  // frame; gate_bit >= 0 stops the ticks for 100 cycles mid data bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap,
                            input int abort_bit, input int gate_bit);
    exp_t e;
    @(negedge sysclk);
    uart_rx = 1'b0;
    e.good = stop_ok;
    e.data = d;
    e.edge_tick = tick_total;
    if (abort_bit < 0) exp_q.push_back(e);
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      @(negedge sysclk);
      uart_rx = d[i];
      if (i == abort_bit) begin
        wait_ticks(OS / 2);
        @(negedge sysclk);
        #1;
        reset      = 1'b1;
        uart_rx    = 1'b1;
        model_data = 8'h00;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        return;
      end else if (i == gate_bit) begin
        wait_ticks(OS / 2);
        tick_gate = 1'b1;
        repeat (100) @(posedge sysclk);
        tick_gate = 1'b0;
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    @(negedge sysclk);
    uart_rx = stop_ok;
    wait_ticks(OS);
    if (gap > 0) begin
      @(negedge sysclk);
      uart_rx = 1'b1;
      wait_ticks(gap);
    end
  endtask

  task automatic glitch(input int n);
    @(negedge sysclk);
    uart_rx = 1'b0;
    wait_ticks(n);
    @(negedge sysclk);
    uart_rx = 1'b1;
    wait_ticks(20);
  endtask

  initial begin
    int s0;
    int e0;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h0);
    check("reset_rx_status", {31'd0, rx_status}, 32'd0);
    check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    wait_ticks(4);

    // Good 0x55
    s0 = status_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, 20, -1, -1);
    check("t55_data", {24'd0, rx_data}, 32'h55);
    check("t55_status_count", status_cnt - s0, 1);
    check("t55_err_count", err_cnt - e0, 0);

    // Short low pulse on the line: rejected as a glitch
    s0 = status_cnt; e0 = err_cnt;
    glitch(4);
    check("glitch_status_count", status_cnt - s0, 0);
    check("glitch_err_count", err_cnt - e0, 0);
    check("glitch_data", {24'd0, rx_data}, 32'h55);

    // 0x3C with a low stop bit
    s0 = status_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 20, -1, -1);
    check("ferr_err_count", err_cnt - e0, 1);
    check("ferr_status_count", status_cnt - s0, 0);
    check("ferr_data", {24'd0, rx_data}, 32'h55);

    // Back-to-back 0x00, 0xFF with no idle gap
    s0 = status_cnt;
    send_frame(8'h00, 1'b1, 0, -1, -1);
    send_frame(8'hFF, 1'b1, 20, -1, -1);
    check("b2b_status_count", status_cnt - s0, 2);
    check_range("b2b_spacing", last_status_tick - prev_status_tick, 156, 164);
    check("b2b_data", {24'd0, rx_data}, 32'hFF);

    // Reset during data bit 4 of 0xA5, then a full 0xA5
    s0 = status_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 0, 4, -1);
    wait_ticks(20);
    check("abort_data", {24'd0, rx_data}, 32'h0);
    check("abort_status_count", status_cnt - s0, 0);
    check("abort_err_count", err_cnt - e0, 0);
    send_frame(8'hA5, 1'b1, 20, -1, -1);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_status_count", status_cnt - s0, 1);

    // Ticks gated off mid data bit 3 of 0xC3
    s0 = status_cnt;
    send_frame(8'hC3, 1'b1, 20, -1, 3);
    check("gate_data", {24'd0, rx_data}, 32'hC3);
    check("gate_status_count", status_cnt - s0, 1);

    // Randomized traffic: bytes, stop bits, gaps, glitches
    for (int r = 0; r < 30; r++) begin
      logic [7:0] d;
      bit ok;
      int gap;
      if ($urandom_range(0, 99) < 15) glitch($urandom_range(1, 5));
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 99) >= 20);
      gap = ok ? $urandom_range(0, 12) : $urandom_range(10, 20);
      send_frame(d, ok, gap, -1, -1);
    end
    wait_ticks(30);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
